i2c_master_ctrl: RTL
====================

# i2c_master_ctrl

Synthesizable single-byte I2C master controller that generates the bus traffic the I2C slave consumes. It replaces the behavioural master task in the slave bench and serves as the bus front end for on-chip masters. It takes one command (address, R/W, write byte), runs START, address, data and STOP phases on open-drain SDA/SCL, and returns the read byte plus ACK status. Clock stretching by the slave is honoured.

## Interface
- DIV, 4: clk cycles per SCL quarter-period (minimum 2); SCL period = 4*DIV clk cycles.
- clk  in  1  system clock; all logic on posedge.
- rst_n  in  1  reset, synchronous, active-low.
- start  in  1  command strobe; sampled only when busy=0.
- dev_addr  in  7  target address, latched on accepted start.
- rw  in  1  0=write, 1=read, latched on accepted start.
- wr_data  in  8  write byte, latched on accepted start.
- busy  out  1  high from cycle after accepted start until done pulse.
- done  out  1  one-cycle pulse at end of transaction.
- ack_err  out  1  valid with done and held until next accepted start; 1 = address or data NACK.
- rd_data  out  8  read byte; updated only on successful read completion.
- sda_oe  out  1  1 = pull SDA low; top level drives 0 when sda_oe=1, otherwise 'z'.
- sda_in  in  1  sampled SDA line.
- scl_oe  out  1  1 = pull SCL low.
- scl_in  in  1  sampled SCL line, used for stretch detection.

## Operation
- States: IDLE, START, ADDR, ADDR_ACK, WRITE, WR_ACK, READ, RD_NACK, STOP, DONE.
- Bit timing: phase counter 0..3, each DIV cycles. SCL is low in phases 0-1 and released in phases 2-3. SDA changes only on entry to phase 0. SDA is sampled on the last cycle of phase 2.
- IDLE: sda_oe=0, scl_oe=0. start=1 latches inputs, loads shift register {dev_addr,rw}, and enters START.
- START: SCL released; SDA pulled low for 2*DIV cycles; then SCL pulled low for 2*DIV cycles. Then ADDR.
- ADDR: 8 bits MSB first; sda_oe = ~bit.
- ADDR_ACK: SDA released. Sampled 0 -> WRITE (rw=0) or READ (rw=1). Sampled 1 -> ack_err=1, then STOP.
- WRITE: 8 bits of wr_data, MSB first. WR_ACK: SDA released; sampled 1 sets ack_err. Always then STOP.
- READ: SDA released; 8 samples shifted in MSB first. RD_NACK: master releases SDA (NACK, last byte). Then STOP. rd_data is loaded at STOP completion.
- STOP: phases 0-1 SCL low and SDA low; phase 2 SCL released; phase 3 SDA released (STOP). Then DONE.
- DONE: done=1 for one cycle, busy=0, return to IDLE.
- Clock stretching: in phase 2 or 3 with scl_oe=0 and scl_in=0, the divider counter holds. Counting resumes the cycle after scl_in=1.
- start while busy=1 is ignored; no queueing.

## Timing
- Reset values: sda_oe=0, scl_oe=0, busy=0, done=0, ack_err=0, rd_data=8'h00, state IDLE.
- Reset asserted mid-transfer releases both lines on the next posedge. No STOP is generated and no done pulse is issued.
- Latency with start accepted at edge N and no stretching: busy=1 at N+1. START lasts 4*DIV cycles and each bit is 4*DIV cycles.
  - Write or read, 20 bit periods: done at N+1+80*DIV.
  - Address NACK, START + 9 bits + STOP: done at N+1+44*DIV.
- A stretch of S cycles adds exactly S cycles to done.
- Back-to-back: start asserted in the same cycle as done is ignored. The earliest accepted start is the cycle after done.

## Test plan
- Reset: hold rst_n=0 for 5 cycles while start=1 -> all outputs at reset values; no bus activity.
- Write, DIV=4: addr 7'h50, rw=0, wr_data 8'hA5, bench slave ACKs both bytes.
  - Bench decodes START, byte 8'hA0, byte 8'hA5, STOP.
  - ack_err=0; done at exactly 321 cycles after accepted start.
- Read: addr 7'h50, rw=1, bench slave ACKs address and returns 8'h3C.
  - rd_data=8'h3C; master NACK observed on 9th data clock; STOP follows.
- Address NACK: no slave responds to addr 7'h12 -> ack_err=1, STOP issued after 9th clock, done at 177 cycles (DIV=4), rd_data unchanged.
- Clock stretching: slave holds SCL low for 37 cycles after the address ACK clock -> no SDA change during the stretch; done delayed by exactly 37 cycles; data intact.
- Mid-transfer reset and busy-start: start pulse during WRITE is ignored. rst_n=0 during READ releases sda_oe and scl_oe next cycle with no done pulse, and a following transaction completes normally.

Source files
------------

// File: rtl/i2c_master_ctrl.sv
// i2c_master_ctrl: single-byte I2C master (START, addr, data, STOP)
// on open-drain SDA/SCL with slave clock stretching and ACK status.
//
// Ports:
//   clk, rst_n            clock, synchronous active-low reset
//   start                 command strobe, taken only when idle
//   dev_addr, rw, wr_data command fields, latched on accepted start
//   busy, done            transaction in flight / one-cycle end pulse
//   ack_err               address or data NACK seen (valid with done)
//   rd_data               read byte, updated on successful read only
//   sda_oe, sda_in        SDA pull-low enable / sampled SDA line
//   scl_oe, scl_in        SCL pull-low enable / sampled SCL line
module i2c_master_ctrl #(
  parameter int DIV = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [6:0] dev_addr,
  input  logic       rw,
  input  logic [7:0] wr_data,
  output logic       busy,
  output logic       done,
  output logic       ack_err,
  output logic [7:0] rd_data,
  output logic       sda_oe,
  input  logic       sda_in,
  output logic       scl_oe,
  input  logic       scl_in
);

  localparam int CW = $clog2(DIV);
  localparam logic [CW-1:0] DIV_LAST = CW'(DIV - 1);

  typedef enum logic [3:0] {
    IDLE,
    START,
    ADDR,
    ADDR_ACK,
    WRITE,
    WR_ACK,
    READ,
    RD_NACK,
    STOP,
    DONE
  } state_t;

  state_t          state;
  logic [CW-1:0]   div_cnt;
  logic [1:0]      phase;
  logic [2:0]      bit_cnt;
  logic [7:0]      shreg;
  logic [7:0]      rd_shift;
  logic [7:0]      wr_q;
  logic            rw_q;
  logic            samp;
  logic            active;
  logic            hold;
  logic            tick;

  assign active = (state != IDLE) && (state != DONE);

  // SCL released by us but still low on the wire: slave is stretching.
  assign hold = phase[1] & ~scl_oe & ~scl_in;

  assign tick = (div_cnt == DIV_LAST) & ~hold;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      div_cnt  <= '0;
      phase    <= '0;
      bit_cnt  <= '0;
      shreg    <= '0;
      rd_shift <= '0;
      wr_q     <= '0;
      rw_q     <= 1'b0;
      samp     <= 1'b0;
      sda_oe   <= 1'b0;
      scl_oe   <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      ack_err  <= 1'b0;
      rd_data  <= '0;
    end else begin
      done <= 1'b0;

      if (active && !hold) begin
        div_cnt <= (div_cnt == DIV_LAST) ? '0
                 : div_cnt + 1'b1;
      end

      if (active && tick) begin
        phase <= phase + 2'd1;
      end

      unique case (state)
        IDLE: begin
          if (start) begin
            state   <= START;
            shreg   <= {dev_addr, rw};
            rw_q    <= rw;
            wr_q    <= wr_data;
            ack_err <= 1'b0;
            busy    <= 1'b1;
            div_cnt <= '0;
            phase   <= '0;
            // START condition: SDA falls while SCL is high.
            sda_oe  <= 1'b1;
            scl_oe  <= 1'b0;
          end
        end

        DONE: begin
          state <= IDLE;
        end

        default: begin
          if (tick) begin
            unique case (phase)
              2'd1: begin
                // START pulls SCL low here; every bit releases it.
                scl_oe <= (state == START);
              end

              2'd2: begin
                samp <= sda_in;
                if (state == READ) begin
                  rd_shift <= {rd_shift[6:0], sda_in};
                end
                // STOP condition: SDA rises while SCL is high.
                if (state == STOP) begin
                  sda_oe <= 1'b0;
                end
              end

              2'd3: begin
                scl_oe <= (state != STOP);
                unique case (state)
                  START: begin
                    state   <= ADDR;
                    bit_cnt <= 3'd7;
                    sda_oe  <= ~shreg[7];
                  end

                  ADDR, WRITE: begin
                    if (bit_cnt == 3'd0) begin
                      state  <= (state == ADDR) ? ADDR_ACK
                              : WR_ACK;
                      sda_oe <= 1'b0;
                    end else begin
                      bit_cnt <= bit_cnt - 1'b1;
                      shreg   <= {shreg[6:0], 1'b0};
                      sda_oe  <= ~shreg[6];
                    end
                  end

                  ADDR_ACK: begin
                    if (samp) begin
                      ack_err <= 1'b1;
                      state   <= STOP;
                      sda_oe  <= 1'b1;
                    end else if (rw_q) begin
                      state   <= READ;
                      bit_cnt <= 3'd7;
                      sda_oe  <= 1'b0;
                    end else begin
                      state   <= WRITE;
                      bit_cnt <= 3'd7;
                      shreg   <= wr_q;
                      sda_oe  <= ~wr_q[7];
                    end
                  end

                  WR_ACK: begin
                    if (samp) begin
                      ack_err <= 1'b1;
                    end
                    state  <= STOP;
                    sda_oe <= 1'b1;
                  end

                  READ: begin
                    if (bit_cnt == 3'd0) begin
                      // Released SDA on the 9th clock is the NACK.
                      state  <= RD_NACK;
                      sda_oe <= 1'b0;
                    end else begin
                      bit_cnt <= bit_cnt - 1'b1;
                    end
                  end

                  RD_NACK: begin
                    state  <= STOP;
                    sda_oe <= 1'b1;
                  end

                  STOP: begin
                    state <= DONE;
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    if (rw_q && !ack_err) begin
                      rd_data <= rd_shift;
                    end
                  end

                  default: begin
                    state <= IDLE;
                  end
                endcase
              end

              default: ;
            endcase
          end
        end
      endcase
    end
  end

endmodule
